// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse key timer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int unsigned DefCntW      = 8;
  localparam int unsigned DefDebounce  = 5;
  localparam int unsigned DefDashMin   = 20;
  localparam int unsigned DefLetterGap = 30;
  localparam int unsigned DefWordGap   = 70;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a tick-based debouncer for the raw key.
module morse_debounce
  import morse_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DefDebounce
) (
  input  logic Clock,
  input  logic Reset,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int unsigned DbW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           r_level;
  logic [DbW-1:0] r_cnt;
  logic           w_differ;

  assign w_differ = r_sync2 ^ r_level;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // A matching tick restarts the count; only an unbroken run flips the level.
      if (tick) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (r_cnt == DbW'(DEBOUNCE - 1)) begin
          r_cnt   <= '0;
          r_level <= ~r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign level = r_level;

endmodule

// File: rtl/morse_key_timer.sv
// Classifies debounced key presses into dot/dash and release gaps into letter/word ends.
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DEBOUNCE   = DefDebounce,
  parameter int unsigned DASH_MIN   = DefDashMin,
  parameter int unsigned LETTER_GAP = DefLetterGap,
  parameter int unsigned WORD_GAP   = DefWordGap
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  input  logic tick,
  output logic dot,
  output logic dash,
  output logic letter_end,
  output logic word_end,
  output logic pressed
);

  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  if (!(DEBOUNCE >= 1 && LETTER_GAP >= 1 && LETTER_GAP < WORD_GAP && WORD_GAP <= CntMax &&
        DASH_MIN <= CntMax)) begin : g_param_check
    $fatal(1, "morse_key_timer: illegal timing parameters");
  end

  state_e             r_state;
  state_e             w_state_next;
  logic               w_level;
  logic               r_level_prev;
  logic               w_rise;
  logic               w_fall;
  logic               w_gap_tick;
  logic [CNT_W-1:0]   r_press_cnt;
  logic [CNT_W-1:0]   r_gap_cnt;
  logic [CNT_W-1:0]   w_press_next;
  logic [CNT_W-1:0]   w_gap_next;
  logic               w_dot;
  logic               w_dash;
  logic               w_letter;
  logic               w_word;
  logic               r_dot;
  logic               r_dash;
  logic               r_letter;
  logic               r_word;

  morse_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .Clock(Clock),
    .Reset(Reset),
    .tick (tick),
    .raw  (key),
    .level(w_level)
  );

  assign w_rise     = w_level & ~r_level_prev;
  assign w_fall     = ~w_level & r_level_prev;
  // Edges win over a coincident tick, so the tick is dropped on an edge cycle.
  assign w_gap_tick = (r_state == GAP) && !w_rise && tick;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_rise) w_state_next = PRESS;
      PRESS:   if (w_fall) w_state_next = GAP;
      GAP: begin
        if (w_rise) begin
          w_state_next = PRESS;
        end else if (w_gap_tick && r_gap_cnt == CNT_W'(WORD_GAP - 1)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_dot    = (r_state == PRESS) && w_fall && (r_press_cnt < CNT_W'(DASH_MIN));
    w_dash   = (r_state == PRESS) && w_fall && (r_press_cnt >= CNT_W'(DASH_MIN));
    w_letter = w_gap_tick && (r_gap_cnt == CNT_W'(LETTER_GAP - 1));
    w_word   = w_gap_tick && (r_gap_cnt == CNT_W'(WORD_GAP - 1));
  end

  always_comb begin
    w_press_next = r_press_cnt;
    if (w_rise) begin
      w_press_next = '0;
    end else if ((r_state == PRESS) && tick && (r_press_cnt != CNT_W'(CntMax))) begin
      w_press_next = r_press_cnt + 1'b1;
    end
    w_gap_next = r_gap_cnt;
    if ((r_state == PRESS) && w_fall) begin
      w_gap_next = '0;
    end else if (w_gap_tick) begin
      w_gap_next = r_gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_level_prev <= 1'b0;
      r_press_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_dot        <= 1'b0;
      r_dash       <= 1'b0;
      r_letter     <= 1'b0;
      r_word       <= 1'b0;
    end else begin
      r_level_prev <= w_level;
      r_press_cnt  <= w_press_next;
      r_gap_cnt    <= w_gap_next;
      r_dot        <= w_dot;
      r_dash       <= w_dash;
      r_letter     <= w_letter;
      r_word       <= w_word;
    end
  end

  assign dot        = r_dot;
  assign dash       = r_dash;
  assign letter_end = r_letter;
  assign word_end   = r_word;
  assign pressed    = w_level;

endmodule

// File: tb/tb_morse_key_timer.sv
// Randomised and directed bench for morse_key_timer against a behavioural reference model.
module tb_morse_key_timer;

  localparam int CW = 4;
  localparam int DB = 2;
  localparam int DM = 3;
  localparam int LG = 3;
  localparam int WG = 7;
  localparam int SAT = (1 << CW) - 1;

  logic Clock;
  logic Reset;
  logic key;
  logic tick;
  logic dot;
  logic dash;
  logic letter_end;
  logic word_end;
  logic pressed;

  int n_checks;
  int n_fail;
  int cnt_dot;
  int cnt_dash;
  int cnt_let;
  int cnt_word;
  int cnt_pressed;

  // Reference model: key history, debounce run length, press/gap durations.
  bit m_s1, m_s2, m_lvl, m_prev;
  int m_run;
  bit m_in_press, m_in_gap;
  int m_press_len, m_gap_len;
  bit m_dot, m_dash, m_let, m_word;

  morse_key_timer #(
    .CNT_W     (CW),
    .DEBOUNCE  (DB),
    .DASH_MIN  (DM),
    .LETTER_GAP(LG),
    .WORD_GAP  (WG)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .key       (key),
    .tick      (tick),
    .dot       (dot),
    .dash      (dash),
    .letter_end(letter_end),
    .word_end  (word_end),
    .pressed   (pressed)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit rise;
    bit fall;
    if (Reset) begin
      {m_s1, m_s2, m_lvl, m_prev, m_in_press, m_in_gap} = '0;
      {m_dot, m_dash, m_let, m_word} = '0;
      m_run = 0;
      m_press_len = 0;
      m_gap_len = 0;
      return;
    end
    rise   = m_lvl && !m_prev;
    fall   = !m_lvl && m_prev;
    m_dot  = m_in_press && fall && (m_press_len < DM);
    m_dash = m_in_press && fall && (m_press_len >= DM);
    m_let  = 1'b0;
    m_word = 1'b0;
    if (rise) begin
      m_in_press  = 1'b1;
      m_in_gap    = 1'b0;
      m_press_len = 0;
    end else if (m_in_press && fall) begin
      m_in_press = 1'b0;
      m_in_gap   = 1'b1;
      m_gap_len  = 0;
    end else if (tick) begin
      if (m_in_press) begin
        m_press_len = (m_press_len + 1 > SAT) ? SAT : m_press_len + 1;
      end else if (m_in_gap) begin
        m_gap_len++;
        if (m_gap_len == LG) m_let = 1'b1;
        if (m_gap_len == WG) begin
          m_word   = 1'b1;
          m_in_gap = 1'b0;
        end
      end
    end
    m_prev = m_lvl;
    if (tick) begin
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = !m_lvl;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = key;
  endfunction

  task automatic cycle(input bit k, input bit t, input bit r);
    key   = k;
    tick  = t;
    Reset = r;
    @(posedge Clock);
    model_step();
    #1;
    check_value("dot", dot, m_dot);
    check_value("dash", dash, m_dash);
    check_value("letter_end", letter_end, m_let);
    check_value("word_end", word_end, m_word);
    check_value("pressed", pressed, m_lvl);
    check_value("dot_dash_excl", dot & dash, 0);
    cnt_dot     += int'(dot);
    cnt_dash    += int'(dash);
    cnt_let     += int'(letter_end);
    cnt_word    += int'(word_end);
    cnt_pressed += int'(pressed);
    @(negedge Clock);
  endtask

  task automatic hold(input bit k, input int n, input bit t);
    for (int i = 0; i < n; i++) cycle(k, t, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_dot = 0;
    cnt_dash = 0;
    cnt_let = 0;
    cnt_word = 0;
    cnt_pressed = 0;
  endtask

  task automatic expect_counts(input string tag, input int d, input int da, input int l,
                               input int w);
    check_value({tag, "_dots"}, cnt_dot, d);
    check_value({tag, "_dashes"}, cnt_dash, da);
    check_value({tag, "_letters"}, cnt_let, l);
    check_value({tag, "_words"}, cnt_word, w);
  endtask

  initial begin
    bit k;
    int n;
    n_checks = 0;
    n_fail = 0;
    clear_counts();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check_value("reset_pressed", pressed, 0);
    check_value("reset_pulses", {dot, dash, letter_end, word_end}, 0);

    // Glitch shorter than the debounce window.
    clear_counts();
    hold(1'b1, 1, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("glitch", 0, 0, 0, 0);
    check_value("glitch_pressed", cnt_pressed, 0);

    // Short press: dot, then letter and word ends.
    clear_counts();
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("short", 1, 0, 1, 1);

    // Long presses: saturating press counter still yields a dash.
    clear_counts();
    hold(1'b1, 30, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("long30", 0, 1, 1, 1);
    clear_counts();
    hold(1'b1, 33, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("long33", 0, 1, 1, 1);

    // Re-press inside the word gap: one extra letter end, no extra word end.
    clear_counts();
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 6, 1'b1);
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("repress", 2, 0, 2, 1);

    // Reset mid-press, key released shortly after.
    clear_counts();
    hold(1'b1, 10, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1, 1'b1);
    hold(1'b0, 20, 1'b1);
    expect_counts("rst_press", 0, 0, 0, 0);

    // No ticks: nothing may advance.
    clear_counts();
    hold(1'b1, 50, 1'b0);
    hold(1'b0, 10, 1'b0);
    check_value("notick_pressed", cnt_pressed, 0);
    expect_counts("notick", 0, 0, 0, 0);
    hold(1'b0, 5, 1'b1);

    // Random key runs, sparse ticks and occasional resets.
    for (int s = 0; s < 400; s++) begin
      k = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 25));
      for (int i = 0; i < n; i++) begin
        cycle(k, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
    end
    hold(1'b0, 40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_timer.md
MORSE_KEY_TIMER -- requirements
Module: morse_key_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the tick counters.
REQ-002 SHALL have parameter DEBOUNCE, default 5: consecutive ticks a raw key level must hold before it is accepted.
REQ-003 SHALL have parameter DASH_MIN, default 20: press length in ticks at or above which a press is classified as a dash.
REQ-004 SHALL have parameter LETTER_GAP, default 30: release length in ticks that ends a letter.
REQ-005 SHALL have parameter WORD_GAP, default 70: release length in ticks that ends a word.
REQ-006 SHALL have port Clock, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port key, input, 1 bit: raw asynchronous telegraph key, high while pressed.
REQ-009 SHALL have port tick, input, 1 bit: single-cycle time-base strobe; all durations are counted in ticks.
REQ-010 SHALL have port dot, output, 1 bit: single-cycle pulse, one per short press.
REQ-011 SHALL have port dash, output, 1 bit: single-cycle pulse, one per long press.
REQ-012 SHALL have port letter_end, output, 1 bit: single-cycle pulse when the release gap reaches LETTER_GAP; the consumer latches its symbol, then clears its decoder.
REQ-013 SHALL have port word_end, output, 1 bit: single-cycle pulse when the release gap reaches WORD_GAP.
REQ-014 SHALL have port pressed, output, 1 bit: registered, debounced key level.

Function
REQ-015 SHALL synchronise key through two flip-flops before any other use.
REQ-016 SHALL change the debounced level only after the synchronised key differs from it on DEBOUNCE consecutive ticks; any tick on which they match SHALL zero the debounce count.
REQ-017 SHALL implement an FSM with states IDLE, PRESS and GAP.
REQ-018 SHALL move from IDLE or GAP to PRESS on a debounced rising edge and zero the press counter.
REQ-019 In PRESS, SHALL increment the press counter on each tick, saturating at 2^CNT_W-1.
REQ-020 On a debounced falling edge in PRESS, SHALL go to GAP and, in the next cycle, pulse dash if the press count >= DASH_MIN, otherwise pulse dot.
REQ-021 A press of 0 ticks SHALL be classified as a dot.
REQ-022 dot and dash SHALL never be high in the same cycle, and SHALL emit exactly one pulse per press.
REQ-023 On entry to GAP, SHALL zero the gap counter; in GAP it SHALL increment on each tick.
REQ-024 SHALL pulse letter_end exactly once, in the cycle after the gap count reaches LETTER_GAP.
REQ-025 SHALL pulse word_end exactly once, in the cycle after the gap count reaches WORD_GAP, and then return to IDLE.
REQ-026 A rising edge in GAP before LETTER_GAP SHALL suppress letter_end and word_end; a rising edge between LETTER_GAP and WORD_GAP SHALL suppress word_end only.
REQ-027 When an edge and a tick occur in the same cycle, the edge SHALL take precedence and the tick SHALL NOT be counted.
REQ-028 While tick is low, no counter SHALL advance.
REQ-029 In IDLE, all pulse outputs SHALL stay low.
REQ-030 SHALL require LETTER_GAP < WORD_GAP <= 2^CNT_W-1 and DASH_MIN <= 2^CNT_W-1; an elaboration assertion SHALL enforce this.

Reset
REQ-031 Reset SHALL force the FSM to IDLE; the synchroniser, the debounced level and all counters to 0; and dot, dash, letter_end, word_end and pressed to 0, from the next edge.
REQ-032 Reset asserted mid-press SHALL produce no dot or dash pulse; a key still held after Reset SHALL register as a new press after DEBOUNCE ticks.
REQ-033 Reset asserted during GAP SHALL suppress any pending letter_end or word_end.

Structure
REQ-034 Package morse_pkg SHALL hold the state enum (IDLE, PRESS, GAP) and the default timing constants.
REQ-035 Synchroniser plus debouncer SHALL be one sub-module, morse_debounce (ports: Clock, Reset, tick, raw, level).
REQ-036 All outputs SHALL be registered.

Verification (DEBOUNCE=2, DASH_MIN=3, LETTER_GAP=3, WORD_GAP=7, CNT_W=4, tick=1 unless stated)
REQ-037 key high 1 cycle, then low -> no dot, dash or pressed activity.
REQ-038 key high 2 ticks past debounce, then released -> one dot pulse, then letter_end at gap 3 and word_end at gap 7, then IDLE.
REQ-039 key high 30 cycles -> press count saturates at 15; one dash pulse on release.
REQ-040 dot, release 5 ticks, press again -> letter_end once and no word_end; the next release yields a fresh dot or dash.
REQ-041 Reset pulsed mid-press, key released 2 cycles later -> no dot or dash; all outputs 0.
REQ-042 tick=0 for 50 cycles with key held -> pressed stays 0 and no pulses.
